servo_pwm_bank: RTL

//   Multi-channel RC-servo PWM generator. One shared prescaler and one shared frame counter drive NUM_CH outputs.

---
 rtl/servo_pwm_bank_pkg.sv | 23 ++
 rtl/servo_pwm_bank_prescaler.sv | 29 ++
 rtl/servo_pwm_bank.sv | 101 ++++++++++
 3 files changed

// File: rtl/servo_pwm_bank_pkg.sv
// Purpose : shared defaults, address-width helper and tick-rate constants for the servo PWM bank.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package servo_pwm_bank_pkg;

    // Default build of the servo bank.
    localparam int DEF_NUM_CH       = 8;
    localparam int DEF_CLK_DIV      = 31;
    localparam int DEF_POS_W        = 10;
    localparam int DEF_FRAME_W      = 12;
    localparam int DEF_PULSE_OFFSET = 0;

    // Prescaler divide values that give a 1 us PWM tick at common system clocks.
    localparam int CLK_DIV_1US_AT_25MHZ  = 25;
    localparam int CLK_DIV_1US_AT_50MHZ  = 50;
    localparam int CLK_DIV_1US_AT_100MHZ = 100;

    // Channel address width: clog2 of the channel count, never narrower than one bit.
    function automatic int ch_aw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/servo_pwm_bank_prescaler.sv
// Purpose : free-running divider, o_tick high for one clk out of every CLK_DIV clks.
// Latency : o_tick is combinational from the count register (high while count == CLK_DIV-1).
// Backpressure: none, free-running.
// Ports   : i_clk, i_reset (async, active-high), o_tick.
module servo_prescaler #(
    parameter int CLK_DIV = 31
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] r_div_cnt;

    assign o_tick = (r_div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div_cnt <= '0;
        end else if (o_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/servo_pwm_bank.sv
// Purpose : multi-channel RC-servo PWM; shared prescaler and frame counter, per-channel shadowed width/enable.
// Latency : o_servo_out and o_frame_start are registered, 1 clk after the frame counter changes.
// Backpressure: none; one host write accepted every cycle, out-of-range addresses dropped.
// Ports   : i_clk, i_reset (async, active-high), i_wr_en/i_wr_addr/i_wr_pos/i_wr_enable host write,
//           o_servo_out[NUM_CH] PWM pins, o_frame_start one-cycle wrap pulse.
module servo_pwm_bank
    import servo_pwm_bank_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int POS_W        = DEF_POS_W,
    parameter int FRAME_W      = DEF_FRAME_W,
    parameter int PULSE_OFFSET = DEF_PULSE_OFFSET,
    localparam int CH_AW       = ch_aw(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [CH_AW-1:0]  i_wr_addr,
    input  logic [POS_W-1:0]  i_wr_pos,
    input  logic              i_wr_enable,
    output logic [NUM_CH-1:0] o_servo_out,
    output logic              o_frame_start
);

    logic               w_tick;
    logic               w_wrap;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [NUM_CH-1:0]  w_hit;
    logic [NUM_CH-1:0]  r_servo_out;
    logic               r_frame_start;

    servo_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_tick  (w_tick)
    );

    // Frame boundary: the tick that takes the counter from all-ones back to zero.
    assign w_wrap = w_tick && (&r_frame_cnt);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_frame_cnt <= '0;
        end else if (w_tick) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [POS_W-1:0] r_shadow_pos;
        logic             r_shadow_en;
        logic [POS_W-1:0] r_pos_act;
        logic             r_en_act;
        logic             w_sel;
        logic [FRAME_W:0] w_limit;

        // Equality against a channel index below NUM_CH also rejects every address >= NUM_CH.
        assign w_sel = i_wr_en && (i_wr_addr == CH_AW'(g));

        // The active copy samples the shadow's pre-edge value, so a write landing on
        // the wrap edge is deferred to the following frame.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_shadow_pos <= '0;
                r_shadow_en  <= 1'b0;
                r_pos_act    <= '0;
                r_en_act     <= 1'b0;
            end else begin
                if (w_sel) begin
                    r_shadow_pos <= i_wr_pos;
                    r_shadow_en  <= i_wr_enable;
                end
                if (w_wrap) begin
                    r_pos_act <= r_shadow_pos;
                    r_en_act  <= r_shadow_en;
                end
            end
        end

        // One extra bit so pos + offset can never wrap.
        assign w_limit  = (FRAME_W + 1)'(r_pos_act) + (FRAME_W + 1)'(PULSE_OFFSET);
        assign w_hit[g] = r_en_act && ({1'b0, r_frame_cnt} < w_limit);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_servo_out   <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_servo_out   <= w_hit;
            r_frame_start <= w_wrap;
        end
    end

    assign o_servo_out   = r_servo_out;
    assign o_frame_start = r_frame_start;

endmodule
